// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction memory geometry and the
// port-arbiter grant encoding.
package cpu_pkg;

  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DW    = 8;
  localparam int unsigned IMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_LOAD
  } imem_grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : requests (bit 0 fetch, bit 1 load)
//   gnt_c[1:0] : combinational one-hot grant
// On a tie the requester not granted most recently wins; history resets to
// "load last" so the first tie goes to requester 0.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic last_load;
  logic last_load_nxt;

  // Grant selection and history update
  always_comb begin
    gnt_c         = 2'b00;
    last_load_nxt = last_load;
    if (req[0] && (!req[1] || last_load)) begin
      gnt_c[0]      = 1'b1;
      last_load_nxt = 1'b0;
    end else if (req[1]) begin
      gnt_c[1]      = 1'b1;
      last_load_nxt = 1'b1;
    end
  end

  // LastGrant register
  always_ff @(posedge clk) begin
    if (reset) begin
      last_load <= 1'b1;
    end else begin
      last_load <= last_load_nxt;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between CPU fetch and the
// program loader, with round-robin arbitration and a loader lock.
//   clk, reset          : clock, synchronous active-high reset
//   fetch_req/addr      : CPU read request
//   fetch_valid/data    : registered read response (one cycle after grant)
//   load_req/addr/data  : loader write request
//   load_ack            : registered write acknowledge
//   load_lock           : loader session; blocks fetch while high
//   cpu_stall_c         : fetch path must hold its request
//   write_count         : saturating per-session write count
//   mem_addr_c, mem_wr_data_c, mem_wr_en_c : combinational memory port
//   mem_rd_data         : combinational read data from memory
module imem_port_arbiter
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [IMEM_AW-1:0] fetch_addr,
  output logic               fetch_valid,
  output logic [IMEM_DW-1:0] fetch_data,
  input  logic               load_req,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [IMEM_DW-1:0] load_data,
  output logic               load_ack,
  input  logic               load_lock,
  output logic               cpu_stall_c,
  output logic [IMEM_AW:0]   write_count,
  output logic [IMEM_AW-1:0] mem_addr_c,
  output logic [IMEM_DW-1:0] mem_wr_data_c,
  output logic               mem_wr_en_c,
  input  logic [IMEM_DW-1:0] mem_rd_data
);

  localparam int unsigned CW = IMEM_AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IMEM_DEPTH);

  logic          fetch_elig;
  logic          load_elig;
  logic [1:0]    gnt;
  imem_grant_e   grant_c;
  logic          lock_prev;
  logic          lock_rise;
  logic [CW-1:0] count_nxt;

  // Requests are dropped during reset so nothing is granted or remembered
  assign fetch_elig = fetch_req & ~load_lock & ~reset;
  assign load_elig  = load_req & ~reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({load_elig, fetch_elig}),
    .gnt_c (gnt)
  );

  // Grant decode
  always_comb begin
    grant_c = GNT_NONE;
    if (gnt[0]) grant_c = GNT_FETCH;
    else if (gnt[1]) grant_c = GNT_LOAD;
  end

  // Memory port mux; the fetch address is presented whenever load is not granted
  always_comb begin
    mem_addr_c    = fetch_addr;
    mem_wr_data_c = load_data;
    mem_wr_en_c   = 1'b0;
    if (grant_c == GNT_LOAD) begin
      mem_addr_c  = load_addr;
      mem_wr_en_c = 1'b1;
    end
  end

  assign cpu_stall_c = reset | load_lock | (fetch_req & (grant_c != GNT_FETCH));

  // Session start clears the count before a same-cycle write is added
  assign lock_rise = load_lock & ~lock_prev;

  always_comb begin
    count_nxt = write_count;
    if (lock_rise) count_nxt = '0;
    if ((grant_c == GNT_LOAD) && (count_nxt != CNT_MAX)) count_nxt = count_nxt + CW'(1);
  end

  // Response registers, lock history and write counter
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      load_ack    <= 1'b0;
      write_count <= '0;
      lock_prev   <= 1'b0;
    end else begin
      fetch_valid <= (grant_c == GNT_FETCH);
      load_ack    <= (grant_c == GNT_LOAD);
      if (grant_c == GNT_FETCH) fetch_data <= mem_rd_data;
      write_count <= count_nxt;
      lock_prev   <= load_lock;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter with a behavioural 256x8 memory.
module tb_imem_port_arbiter;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               fetch_req;
  logic [IMEM_AW-1:0] fetch_addr;
  logic               fetch_valid;
  logic [IMEM_DW-1:0] fetch_data;
  logic               load_req;
  logic [IMEM_AW-1:0] load_addr;
  logic [IMEM_DW-1:0] load_data;
  logic               load_ack;
  logic               load_lock;
  logic               cpu_stall_c;
  logic [IMEM_AW:0]   write_count;
  logic [IMEM_AW-1:0] mem_addr_c;
  logic [IMEM_DW-1:0] mem_wr_data_c;
  logic               mem_wr_en_c;
  logic [IMEM_DW-1:0] mem_rd_data;

  logic [IMEM_DW-1:0] mem [IMEM_DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .load_req      (load_req),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .load_ack      (load_ack),
    .load_lock     (load_lock),
    .cpu_stall_c   (cpu_stall_c),
    .write_count   (write_count),
    .mem_addr_c    (mem_addr_c),
    .mem_wr_data_c (mem_wr_data_c),
    .mem_wr_en_c   (mem_wr_en_c),
    .mem_rd_data   (mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr_c];

  always @(posedge clk) begin
    if (mem_wr_en_c) mem[mem_addr_c] <= mem_wr_data_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    load_req  = 1'b0;
    load_lock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    reset      = 1'b1;
    fetch_req  = 1'b1;
    load_req   = 1'b1;
    load_lock  = 1'b0;
    fetch_addr = 8'h10;
    load_addr  = 8'h40;
    load_data  = 8'h99;

    // Reset held 3 cycles with both requesting
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_wren", 32'(mem_wr_en_c), 32'd0);
      check("rst_stall", 32'(cpu_stall_c), 32'd1);
      tick();
    end
    reset = 1'b0;
    idle();
    #1;
    check("rst_fvalid", 32'(fetch_valid), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    check("rst_count", 32'(write_count), 32'd0);
    check("rst_fdata", 32'(fetch_data), 32'd0);
    check("rst_nowrite", 32'(mem[8'h40]), 32'd0);

    // Fetch only
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    #1;
    check("f_stall", 32'(cpu_stall_c), 32'd0);
    check("f_addr", 32'(mem_addr_c), 32'h10);
    tick();
    fetch_req = 1'b0;
    check("f_valid", 32'(fetch_valid), 32'd1);
    check("f_data", 32'(fetch_data), 32'hA5);
    tick();
    check("f_valid_drop", 32'(fetch_valid), 32'd0);
    check("f_data_hold", 32'(fetch_data), 32'hA5);

    // Both requesting from reset: fetch, load, fetch, load
    do_reset();
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    load_req   = 1'b1;
    load_addr  = 8'h50;
    load_data  = 8'h11;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("rr_wren", 32'(mem_wr_en_c), (c % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_stall", 32'(cpu_stall_c), (c % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      check("rr_fvalid", 32'(fetch_valid), (c % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_ack", 32'(load_ack), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("rr_count", 32'(write_count), 32'd2);
    check("rr_mem", 32'(mem[8'h50]), 32'h11);

    // Locked session: 3 writes of 0x3C to 0x20 while fetch is held
    load_lock = 1'b1;
    load_addr = 8'h20;
    load_data = 8'h3C;
    fetch_addr = 8'h20;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lk_stall", 32'(cpu_stall_c), 32'd1);
      check("lk_addr", 32'(mem_addr_c), 32'h20);
      tick();
      check("lk_ack", 32'(load_ack), 32'd1);
      check("lk_fvalid", 32'(fetch_valid), 32'd0);
    end
    check("lk_count", 32'(write_count), 32'd3);
    // Lock falls: fetch eligible the same cycle, reads the new data
    load_lock = 1'b0;
    load_req  = 1'b0;
    #1;
    check("unlk_stall", 32'(cpu_stall_c), 32'd0);
    tick();
    fetch_req = 1'b0;
    check("raw_valid", 32'(fetch_valid), 32'd1);
    check("raw_data", 32'(fetch_data), 32'h3C);
    check("hold_count", 32'(write_count), 32'd3);

    // 300-write session saturates at 256
    load_lock = 1'b1;
    load_req  = 1'b1;
    load_data = 8'h5A;
    for (int i = 0; i < 300; i++) begin
      load_addr = 8'(i);
      tick();
    end
    check("sat_count", 32'(write_count), 32'd256);
    check("sat_ack", 32'(load_ack), 32'd1);
    check("sat_mem", 32'(mem[8'h2C]), 32'h5A);
    load_lock = 1'b0;
    load_req  = 1'b0;
    tick();
    check("sat_hold", 32'(write_count), 32'd256);
    // New session rise with a same-cycle write counts as 1
    load_lock = 1'b1;
    load_req  = 1'b1;
    load_addr = 8'h00;
    load_data = 8'hC3;
    tick();
    check("new_sess", 32'(write_count), 32'd1);

    // Lock rising with a fetch-only request blocks the fetch
    load_lock = 1'b0;
    load_req  = 1'b0;
    tick();
    load_lock  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    #1;
    check("lrise_stall", 32'(cpu_stall_c), 32'd1);
    check("lrise_wren", 32'(mem_wr_en_c), 32'd0);
    tick();
    check("lrise_fvalid", 32'(fetch_valid), 32'd0);
    check("lrise_count", 32'(write_count), 32'd0);

    // Reset during a would-be granted load: no write, no ack
    idle();
    tick();
    reset     = 1'b1;
    load_req  = 1'b1;
    load_addr = 8'h77;
    load_data = 8'hEE;
    #1;
    check("rl_wren", 32'(mem_wr_en_c), 32'd0);
    tick();
    reset    = 1'b0;
    load_req = 1'b0;
    check("rl_ack", 32'(load_ack), 32'd0);
    fetch_req  = 1'b1;
    fetch_addr = 8'h77;
    tick();
    fetch_req = 1'b0;
    check("rl_fvalid", 32'(fetch_valid), 32'd1);
    check("rl_mem", 32'(fetch_data), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
